// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the uart_trx block: FSM state encodings for the
//   transmit and receive halves, frame geometry, and the default bit period.
//   Ports: none (package).

package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int FRAME_BITS       = 10;    // start + 8 data + stop
    localparam int BAUD_DIV_DEFAULT = 2604;  // 19200 baud at 50 MHz

    typedef enum logic {
        TX_IDLE,
        TX_TRANSMITTING
    } tx_state_t;

    typedef enum logic {
        RX_IDLE,
        RX_RECEIVING
    } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core
//   8N1 deserializer. RX is synchronized through two flops (preset high) and
//   a falling edge on the synchronized line starts a frame. The first
//   interval is half a bit so every later sample lands at a bit midpoint.
//   A start bit that reads back high is treated as a glitch and dropped.
//   After the stop-bit sample a further half bit elapses before rdy is set,
//   which places rdy at the end of the stop bit. The stop bit is not checked.
//   Ports:
//     clk, rst_n  - clock, asynchronous active-low reset
//     RX          - serial input, asynchronous to clk
//     clr_rdy     - synchronous clear of rdy (frame completion wins)
//     rdy         - new byte available in cmd
//     cmd         - last completed byte

module uart_rx_core
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic                 rdy,
    output logic [DATA_BITS-1:0] cmd
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    // Down-counter reload values; an interval of N cycles loads N-1
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       STOP_IDX  = 4'(FRAME_BITS - 1);
    localparam logic [3:0]       END_IDX   = 4'(FRAME_BITS);

    rx_state_t              state;
    rx_state_t              state_nxt;
    logic                   rx_meta;
    logic                   rx_sync;
    logic                   rx_sync_d;
    logic                   start_edge;
    logic [CNT_W-1:0]       baud_cnt;
    logic [3:0]             bit_cnt;     // 0 start, 1..8 data, 9 stop, 10 end
    logic [DATA_BITS-1:0]   shift_reg;

    logic begin_frame;
    logic advance;
    logic abort;
    logic finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_sync_d <= 1'b1;
        end else begin
            rx_meta   <= RX;
            rx_sync   <= rx_meta;
            rx_sync_d <= rx_sync;
        end
    end

    assign start_edge = rx_sync_d & ~rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        begin_frame = 1'b0;
        advance     = 1'b0;
        abort       = 1'b0;
        finish      = 1'b0;
        case (state)
            RX_IDLE: begin
                if (start_edge) begin
                    begin_frame = 1'b1;
                    state_nxt   = RX_RECEIVING;
                end
            end
            RX_RECEIVING: begin
                if (baud_cnt == '0) begin
                    if (bit_cnt == 4'd0 && rx_sync) begin
                        abort     = 1'b1;
                        state_nxt = RX_IDLE;
                    end else if (bit_cnt == END_IDX) begin
                        finish    = 1'b1;
                        state_nxt = RX_IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (begin_frame) begin
                baud_cnt <= HALF_LOAD;
                bit_cnt  <= '0;
            end else if (state == RX_RECEIVING) begin
                if (advance) begin
                    bit_cnt  <= bit_cnt + 4'd1;
                    // The stop-bit sample is followed by a half bit to reach
                    // the end of the frame.
                    baud_cnt <= (bit_cnt == STOP_IDX) ? HALF_LOAD : FULL_LOAD;
                    if (bit_cnt >= 4'd1 && bit_cnt <= 4'(DATA_BITS)) begin
                        shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
                    end
                end else if (abort || finish) begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end else begin
                    baud_cnt <= baud_cnt - 1'b1;
                end
            end
        end
    end

    // cmd only moves on a completed frame so it is stable while rdy is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy <= 1'b0;
            cmd <= '0;
        end else begin
            if (finish) begin
                rdy <= 1'b1;
                cmd <= shift_reg;
            end else if (begin_frame || clr_rdy) begin
                rdy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core
//   8N1 serializer. A one-cycle trmt pulse in IDLE loads {stop, data, start}
//   into a shift register whose LSB drives TX directly, so the start bit
//   appears from the posedge that accepts trmt. Each bit is held for
//   BAUD_DIV cycles; after the tenth shift tx_done is raised and held until
//   the next accepted trmt.
//   Ports:
//     clk, rst_n  - clock, asynchronous active-low reset
//     trmt        - start pulse (ignored while transmitting)
//     tx_data     - byte to send, sampled with trmt
//     TX          - serial output, idles high
//     tx_done     - frame complete flag

module uart_tx_core
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trmt,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 TX,
    output logic                 tx_done
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       LAST_BIT  = 4'(FRAME_BITS - 1);

    tx_state_t              state;
    tx_state_t              state_nxt;
    logic [CNT_W-1:0]       baud_cnt;
    logic [3:0]             bit_cnt;
    logic [FRAME_BITS-1:0]  shift_reg;

    // Control strobes decoded from the FSM
    logic load;
    logic shift;
    logic finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        finish    = 1'b0;
        case (state)
            TX_IDLE: begin
                if (trmt) begin
                    load      = 1'b1;
                    state_nxt = TX_TRANSMITTING;
                end
            end
            TX_TRANSMITTING: begin
                if (baud_cnt == BAUD_LAST) begin
                    shift = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        finish    = 1'b1;
                        state_nxt = TX_IDLE;
                    end
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '1;
            tx_done   <= 1'b0;
        end else begin
            if (load) begin
                shift_reg <= {1'b1, tx_data, 1'b0};
                baud_cnt  <= '0;
                bit_cnt   <= '0;
                tx_done   <= 1'b0;
            end else if (state == TX_TRANSMITTING) begin
                if (shift) begin
                    baud_cnt  <= '0;
                    // Fill with ones so TX rests high once the stop bit is gone
                    shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
                    bit_cnt   <= finish ? 4'd0 : bit_cnt + 4'd1;
                end else begin
                    baud_cnt <= baud_cnt + 1'b1;
                end
            end
            if (finish) begin
                tx_done <= 1'b1;
            end
        end
    end

    assign TX = shift_reg[0];

endmodule

// File: rtl/uart_trx.sv
// uart_trx
//   Full-duplex 8N1 UART for the serial command link. The transmit and
//   receive halves are independent and share only clock, reset and the bit
//   period.
//   Host handshakes:
//     TX side - trmt is a one-cycle request accepted only while idle;
//               tx_done reports completion and stays high until the next
//               accepted trmt (a trmt in a tx_done cycle is accepted).
//     RX side - rdy is raised at the end of each frame and held with cmd
//               stable until clr_rdy or the next start edge clears it; a
//               frame completing in the same cycle as clr_rdy leaves rdy set.
//   Ports:
//     clk, rst_n         - clock, asynchronous active-low reset
//     trmt, tx_data      - transmit request and byte
//     TX, tx_done        - serial out and completion flag
//     RX                 - serial in
//     clr_rdy, rdy, cmd  - receive flag clear, flag, received byte

module uart_trx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trmt,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 TX,
    output logic                 tx_done,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic                 rdy,
    output logic [DATA_BITS-1:0] cmd
);

    uart_tx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (TX),
        .tx_done (tx_done)
    );

    uart_rx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rdy     (rdy),
        .cmd     (cmd)
    );

endmodule

// File: tb/tb_uart_trx.sv
// tb_uart_trx
//   Loopback bench for uart_trx: TX feeds RX except while a glitch is forced
//   onto the RX line. Inputs change on the falling edge; outputs are sampled
//   on the falling edge before any input is changed.

module tb_uart_trx;
    import uart_pkg::*;

    localparam int BAUD = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trmt;
    logic [7:0] tx_data;
    logic       TX;
    logic       tx_done;
    logic       RX;
    logic       clr_rdy;
    logic       rdy;
    logic [7:0] cmd;
    logic       glitch_en;
    logic       glitch_val;

    int n_vec  = 0;
    int n_miss = 0;
    logic [7:0] exp_q[$];

    assign RX = glitch_en ? glitch_val : TX;

    uart_trx #(
        .BAUD_DIV (BAUD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (TX),
        .tx_done (tx_done),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rdy     (rdy),
        .cmd     (cmd)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Called at a falling edge; returns at the falling edge after the load,
    // where the start bit must already be on TX.
    task automatic start_tx(input logic [7:0] data, input bit clr, input bit held_chk);
        if (held_chk) check("tx_done_held", 32'(tx_done), 32'd1);
        trmt    = 1'b1;
        tx_data = data;
        clr_rdy = clr;
        exp_q.push_back(data);
        @(negedge clk);
        trmt    = 1'b0;
        clr_rdy = 1'b0;
        check("tx_done_clr", 32'(tx_done), 32'd0);
        check("start_bit", 32'(TX), 32'd0);
        if (clr) check("rdy_clr", 32'(rdy), 32'd0);
    endtask

    // Follows a frame from its start bit: checks every TX bit period, the
    // tx_done latency, the rdy delay behind tx_done and the received byte.
    // poke_at >= 0 pulses a stray trmt at that cycle of the frame.
    task automatic watch_frame(input logic [7:0] data, input int poke_at, input string tag);
        logic [9:0] frame;
        logic [7:0] exp_b;
        int c;
        int lat;
        bit bad;
        frame = {1'b1, data, 1'b0};
        c   = 0;
        bad = 1'b0;
        while (tx_done !== 1'b1 && c < 20 * BAUD) begin
            if (c < 10 * BAUD && TX !== frame[c / BAUD]) bad = 1'b1;
            if (c == poke_at) begin
                trmt    = 1'b1;
                tx_data = 8'h00;
            end else begin
                trmt = 1'b0;
            end
            c++;
            @(negedge clk);
        end
        trmt = 1'b0;
        check({tag, "_done_time"}, 32'(c), 32'(10 * BAUD));
        check({tag, "_tx_bits"}, 32'(bad), 32'd0);
        check({tag, "_tx_idle"}, 32'(TX), 32'd1);
        lat = 0;
        while (rdy !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_rdy_lat"}, 32'(lat), 32'd3);
        if (exp_q.size() == 0) begin
            check({tag, "_exp_q_empty"}, 32'd1, 32'd0);
        end else begin
            exp_b = exp_q.pop_front();
            check({tag, "_cmd"}, 32'(cmd), 32'(exp_b));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        trmt       = 1'b0;
        tx_data    = 8'h00;
        clr_rdy    = 1'b0;
        glitch_en  = 1'b0;
        glitch_val = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(TX), 32'd1);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        check("rst_rdy", 32'(rdy), 32'd0);
        check("rst_cmd", 32'(cmd), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // First frame
        start_tx(8'h3A, 1'b0, 1'b0);
        watch_frame(8'h3A, -1, "f3a");

        // clr_rdy together with a new request; cmd must hold until frame end
        start_tx(8'hFF, 1'b1, 1'b1);
        check("cmd_stable", 32'(cmd), 32'h3A);
        watch_frame(8'hFF, -1, "fff");
        check("rdy_ff", 32'(rdy), 32'd1);

        // All-zero payload
        start_tx(8'h00, 1'b0, 1'b1);
        watch_frame(8'h00, -1, "f00");

        // Glitch on RX while rdy is clear
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        check("rdy_cleared", 32'(rdy), 32'd0);
        glitch_en  = 1'b1;
        glitch_val = 1'b0;
        repeat (2) @(negedge clk);
        glitch_val = 1'b1;
        repeat (4) @(negedge clk);
        check("glitch_seen", 32'(dut.u_rx.state), 32'(RX_RECEIVING));
        repeat (20) @(negedge clk);
        check("glitch_idle", 32'(dut.u_rx.state), 32'(RX_IDLE));
        check("glitch_rdy", 32'(rdy), 32'd0);
        check("glitch_cmd", 32'(cmd), 32'h00);
        glitch_en = 1'b0;
        repeat (2) @(negedge clk);

        // Stray trmt mid-frame must be ignored
        start_tx(8'h5C, 1'b0, 1'b1);
        watch_frame(8'h5C, 3 * BAUD + 5, "f5c");

        // Reset in the middle of a frame (data bit 4 of 0x66 is low)
        start_tx(8'h66, 1'b0, 1'b1);
        repeat (5 * BAUD + BAUD / 2) @(negedge clk);
        check("pre_rst_tx", 32'(TX), 32'd0);
        check("pre_rst_cmd", 32'(cmd), 32'h5C);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(TX), 32'd1);
        check("mid_rst_tx_done", 32'(tx_done), 32'd0);
        check("mid_rst_rdy", 32'(rdy), 32'd0);
        check("mid_rst_cmd", 32'(cmd), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_cmd", 32'(cmd), 32'd0);

        // Fresh frame after reset
        start_tx(8'hA5, 1'b0, 1'b0);
        watch_frame(8'hA5, -1, "fa5");

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_trx.md
Name: uart_trx

Overview:
- Full-duplex 8N1 UART block: a transmit half serializes a byte on TX, and a receive half deserializes bytes arriving on RX.
- Used as the serial command link. The host side drives trmt/tx_data and reads cmd/rdy.
- The TX and RX halves are independent and share only clk/rst_n and the BAUD_DIV parameter.

Parameters:
- BAUD_DIV, 2604, clk cycles per bit (19200 baud at 50 MHz); must be ≥ 4.

Ports:
- clk  input  1  system clock; everything is posedge-triggered.
- rst_n  input  1  asynchronous active-low reset.
- trmt  input  1  one-cycle pulse that starts transmission of tx_data.
- tx_data  input  8  byte to send; sampled in the cycle trmt is high.
- TX  output  1  serial out; idles high.
- tx_done  output  1  high once a frame completes; held until the next accepted trmt.
- RX  input  1  serial in; asynchronous to clk.
- clr_rdy  input  1  synchronous clear of rdy.
- rdy  output  1  high when cmd holds a new received byte.
- cmd  output  8  last received byte.

Behaviour:
- Frame format: start bit 0, eight data bits LSB first, stop bit 1. Each bit lasts exactly BAUD_DIV cycles.
- Reset values (async, rst_n low): TX=1, tx_done=0, rdy=0, cmd=0. Both FSMs go to IDLE, all counters go to 0, and the RX synchronizer flops preset to 1.
- TX FSM states are IDLE and TRANSMITTING.
  - In IDLE with trmt=1: load the shift register with {1, tx_data, 0}, clear tx_done, and enter TRANSMITTING. The start bit appears on TX from the next posedge.
  - In TRANSMITTING: the baud counter counts to BAUD_DIV-1, then shifts right (filling with 1) and increments bit_cnt.
  - After the 10th shift, which is the end of the stop bit, return to IDLE and set tx_done. TX stays 1.
  - tx_done rises exactly 10*BAUD_DIV cycles after TX first goes low.
  - trmt while TRANSMITTING is ignored.
  - trmt in the same cycle tx_done is high is accepted normally and clears tx_done.
- RX input path: RX passes through a 2-flop synchronizer. A falling edge is detected on the synchronized signal.
- RX FSM states are IDLE and RECEIVING.
  - In IDLE on a falling edge: enter RECEIVING, load the baud counter for a half-bit first interval (BAUD_DIV/2), and clear rdy.
  - Thereafter sample at each bit midpoint, then use full BAUD_DIV intervals. Data bits shift into cmd LSB first.
  - After the stop-bit midpoint sample, wait a further BAUD_DIV/2 cycles (end of stop bit), then set rdy and return to IDLE.
  - rdy therefore rises 2–3 cycles after tx_done in a TX→RX loopback.
  - A sampled start bit of 1 (glitch) aborts to IDLE with no rdy.
  - The stop bit is not checked: a framing error still sets rdy.
- rdy protocol:
  - rdy is set at frame end and cleared by clr_rdy (next posedge) or by a new start edge.
  - If set and clear occur in the same cycle, set wins.
  - cmd is stable while rdy=1, and updates only when a frame completes.
- Reset mid-frame: both halves abort immediately, outputs return to reset values, and no partial byte appears on cmd.
- Back-to-back frames: RX must accept a start edge in the cycle after returning to IDLE.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t and rx_state_t enums;
  - DATA_BITS=8 and FRAME_BITS=10;
  - the default BAUD_DIV localparam.
- Natural sub-modules are uart_tx_core and uart_rx_core, instantiated by uart_trx. Each is about 80–120 lines and owns its baud counter, bit counter and shift register.

Test Plan:
- Loopback (TX wired to RX). Reset, then pulse trmt one cycle with tx_data=0x3A → tx_done rises exactly 10*BAUD_DIV cycles after TX falls; rdy rises after tx_done; cmd=0x3A.
- After a received frame, assert clr_rdy for one cycle together with trmt (tx_data=0xFF) → rdy=0 on the next negedge. The frame then completes with cmd=0xFF and rdy=1.
- Repeat with 0x00 → cmd=0x00. Also check the bit pattern on TX: 0, eight 0s, then 1, each exactly BAUD_DIV cycles.
- Drive a 1–3 cycle low glitch on RX → rdy stays 0, cmd is unchanged, and the FSM returns to IDLE.
- Pulse trmt again mid-frame → it is ignored, and the frame and tx_done timing are unchanged. Pulse trmt in the same cycle tx_done is high → the new frame starts and tx_done clears.
- Assert rst_n low at mid-frame → TX=1, tx_done=0, rdy=0, cmd=0 immediately. After reset is released, a fresh frame with 0xA5 is received correctly.
